uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter. Replaces the fixed 8N1 shift/count/mux datapath with one self-timed block. It has an internal baud divider, configurable data width, parity and stop bits, and a valid/ready input handshake. It sits between the host-side byte source and the tx pin.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9; sent LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2
CLKS_PER_BIT, 16, clk cycles per bit period; legal >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  DATA_BITS  payload; sampled only on handshake
tx_valid  input  1  source has a payload on tx_data
tx_ready  output  1  block can accept a payload this cycle
tx_out  output  1  serial line, idle high
tx_busy  output  1  a frame is on the line (any state except IDLE)
tx_done  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_out=1, tx_ready=1, tx_busy=0, tx_done=0; baud and bit counters = 0; shift and hold registers cleared.
- Handshake: transfer occurs on the rising edge where tx_valid && tx_ready. tx_data is latched into the shift register on that edge. tx_valid without tx_ready has no effect; the source must hold tx_data stable until transfer.
- Frame: START(0), DATA_BITS data bits LSB first, optional PARITY, STOP_BITS ones. Each bit drives tx_out for exactly CLKS_PER_BIT cycles.
- Frame length: F = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: tx_out is registered and goes low in the cycle after the handshake edge.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY_MODE != 0) -> STOP -> IDLE. Transitions occur only on the baud-counter terminal count (CLKS_PER_BIT-1). DATA leaves after bit index DATA_BITS-1. STOP leaves after the STOP_BITS-th stop period.
- Parity: computed from the latched payload at handshake. Even: XOR of the data bits. Odd: inverted XOR.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT); bit counter is $clog2(DATA_BITS+1). Both wrap to 0 at terminal count; no overflow is possible.
- tx_ready is 1 only in IDLE (base build). It drops the cycle after the handshake.
- Frame end: on the terminal count of the last stop bit the FSM enters IDLE. In the following cycle tx_done=1 for exactly one cycle, tx_ready=1, tx_busy=0, and tx_out=1.
- Back-to-back (base build): if tx_valid stays high, the next handshake occurs in the tx_done cycle. The line therefore shows exactly one idle-high clk cycle between frames.
- Reset mid-frame: tx_out returns to 1 immediately (async). The frame is aborted and tx_done is not pulsed. The block is ready one cycle after reset release.
- Illegal parameters: elaboration error via $error in a generate check.

Optional Feature:
Macro UART_TX_HOLD_EN.
- Defined: adds a one-entry holding register. tx_ready = hold register empty, so one payload is accepted while a frame is in flight. When the current frame's last stop period ends and the hold register is full, the FSM goes STOP -> START directly with zero idle cycles. tx_done still pulses once per frame, in the cycle after each frame's final stop period. Reset clears the hold register.
- Undefined: no hold register; behaviour is exactly as specified above.

Test Plan:
- DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1, CLKS_PER_BIT=4; send 0x55 -> tx_out shows 0,1,0,1,0,1,0,1,0,1, each for 4 cycles, starting 1 cycle after the handshake; tx_done pulses at cycle 41 after the handshake; tx_busy high for 40 cycles.
- PARITY_MODE=1, send 0x07 -> parity bit 1. PARITY_MODE=2, send 0x07 -> parity bit 0. PARITY_MODE=2, send 0x00 -> parity bit 1. Each frame is 44 cycles.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=3, send 0x1F -> 0, 1x5, 1, 1, each for 3 cycles; frame is 24 cycles; a 6th data bit is never emitted.
- tx_valid held high with 0xA5 then 0x3C, base build -> exactly 1 idle-high cycle between frames, 2 tx_done pulses. Same stimulus with UART_TX_HOLD_EN -> 0 idle cycles; the second handshake occurs during the first frame.
- Assert reset during DATA bit 3 -> tx_out=1 immediately, no tx_done pulse; after release, a new 0x81 frame transmits correctly.
- tx_valid=1 while tx_busy=1 (base build), with tx_data changed mid-frame -> current frame bits unchanged; no handshake until tx_ready=1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Self-timed UART transmitter: internal baud divider, DATA_BITS payload
//   sent LSB first, optional parity bit, STOP_BITS stop bits. Accepts one
//   payload per valid/ready handshake and drives a registered serial line.
//
// Handshake: a payload transfers on the rising edge where tx_valid and
//   tx_ready are both high. tx_data is latched on that edge. tx_valid alone
//   has no effect, and the source holds tx_data stable until the transfer.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   tx_data   in   payload, sampled only on the handshake edge
//   tx_valid  in   source offers a payload
//   tx_ready  out  a payload can be accepted this cycle
//   tx_out    out  serial line, idle high, registered
//   tx_busy   out  a frame is on the line (state other than IDLE)
//   tx_done   out  one-cycle pulse in the cycle after the last stop bit
//
// Optional build macro UART_TX_HOLD_EN: adds a one-entry holding register
//   so the next payload can be accepted while a frame is in flight; a held
//   payload starts immediately after the current frame's last stop period.
//   Without the macro tx_ready is high only in IDLE.
//
// The FSM state is held in the enum-typed signal state_q for checker binding.

module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end

  localparam int BAUD_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   out_q, out_d;
  logic                   done_q, done_d;

  logic                   accept;
  logic                   baud_last;
  logic                   can_start;
  logic                   start_frame;
  logic [DATA_BITS-1:0]   start_word;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~(^d) : (^d);
  endfunction

  assign accept    = tx_valid && tx_ready;
  assign baud_last = (baud_q == BAUD_LAST);

`ifdef UART_TX_HOLD_EN
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;

  // A held payload always wins over the input port so frames stay in order.
  assign tx_ready   = ~hold_full_q;
  assign can_start  = hold_full_q | accept;
  assign start_word = hold_full_q ? hold_q : tx_data;
`else
  assign tx_ready   = (state_q == IDLE);
  assign can_start  = accept;
  assign start_word = tx_data;
`endif

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    out_d       = out_q;
    done_d      = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_HOLD_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    case (state_q)
      IDLE: begin
        out_d       = 1'b1;
        start_frame = can_start;
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          out_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              state_d = PARITY;
              out_d   = par_q;
            end else begin
              state_d = STOP;
              out_d   = 1'b1;
            end
          end else begin
            // Shift first so the next bit is always at position 0.
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            out_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
          out_d   = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d       = '0;
            done_d      = 1'b1;
            state_d     = IDLE;
            out_d       = 1'b1;
            // With a held payload the next frame starts with no idle cycle.
            start_frame = can_start;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        out_d   = 1'b1;
      end
    endcase

    // Parity is fixed at load time from the payload that enters the shifter.
    if (start_frame) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = start_word;
      par_d   = parity_of(start_word);
      out_d   = 1'b0;
    end

`ifdef UART_TX_HOLD_EN
    if (start_frame && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    // A payload not consumed directly by a frame start parks in the hold slot.
    if (accept && !(start_frame && !hold_full_q)) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  assign tx_out  = out_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame. Four instances cover the configurations:
//   0: 8 data, no parity, 1 stop, 4 clk/bit
//   1: 8 data, even parity, 1 stop, 4 clk/bit
//   2: 8 data, odd parity, 1 stop, 4 clk/bit
//   3: 5 data, no parity, 2 stop, 3 clk/bit
// Expected line waveforms come from a frame model built as a bit queue.

module tb_uart_tx_frame;

`ifdef UART_TX_HOLD_EN
  localparam bit READY_IN_FRAME = 1'b1;
  localparam int GAP            = 0;
`else
  localparam bit READY_IN_FRAME = 1'b0;
  localparam int GAP            = 1;
`endif

  localparam int DB  [4] = '{8, 8, 8, 5};
  localparam int PM  [4] = '{0, 1, 2, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};
  localparam int CPB [4] = '{4, 4, 4, 3};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       tx_out   [4];
  logic       tx_busy  [4];
  logic       tx_done  [4];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) u1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) u2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
  uart_tx_frame #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(3)) u3 (
    .clk(clk), .reset(reset), .tx_data(tx_data[3][4:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  // ---------------- reference model ----------------
  // Builds the expected line, one entry per clk cycle starting with the cycle
  // after the handshake edge; returns the frame length in cycles.
  function automatic int build_line(input int d, input logic [7:0] val,
                                    output logic [127:0] line);
    logic [0:0] exp_q[$];
    logic       p;
    logic [0:0] b;
    int         k;
    k = 0;
    p = (PM[d] == 2);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB[d]; i++) begin
      exp_q.push_back(val[i]);
      p = p ^ val[i];
    end
    if (PM[d] != 0) exp_q.push_back(p);
    for (int i = 0; i < SB[d]; i++) exp_q.push_back(1'b1);
    line = '1;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int c = 0; c < CPB[d]; c++) begin
        line[k] = b[0];
        k++;
      end
    end
    return k;
  endfunction

  // ---------------- driver tasks ----------------
  // Offers val on instance d and returns after the handshake edge (+1).
  task automatic handshake(input int d, input logic [7:0] val, input bit keep,
                           output bit ok);
    ok = 1'b0;
    @(negedge clk);
    tx_data[d]  = val;
    tx_valid[d] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    if (!keep) tx_valid[d] = 1'b0;
  endtask

  // Sends one payload and checks the full frame, the done cycle and the
  // cycle after it. With jam set, tx_valid is held high with changing data
  // throughout the frame.
  task automatic check_frame(input int d, input logic [7:0] val, input bit jam,
                             input string name);
    logic [127:0] exp_line, obs_line;
    int           f;
    bit           ok;
    int           e_busy, e_done, e_ready;
    e_busy = 0; e_done = 0; e_ready = 0;
    f = build_line(d, val, exp_line);
    obs_line = '1;
    handshake(d, val, 1'b0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s handshake: tx_ready not seen in 200 cycles", name);
      return;
    end
    for (int n = 1; n <= f; n++) begin
      @(negedge clk);
      obs_line[n-1] = tx_out[d];
      if (tx_busy[d] !== 1'b1) e_busy++;
      if (tx_done[d] !== 1'b0) e_done++;
      if (tx_ready[d] !== READY_IN_FRAME) e_ready++;
      if (jam) begin
        tx_valid[d] = 1'b1;
        tx_data[d]  = 8'($urandom_range(0, 255));
      end
    end
    total++;
    if (obs_line !== exp_line) begin
      bad++;
      $display("FAIL %s line: got %h required %h", name, obs_line, exp_line);
    end
    total++;
    if (e_busy != 0) begin
      bad++;
      $display("FAIL %s busy: %0d frame cycles with tx_busy low, required 0", name, e_busy);
    end
    total++;
    if (e_done != 0) begin
      bad++;
      $display("FAIL %s early_done: %0d frame cycles with tx_done high, required 0", name, e_done);
    end
    total++;
    if (e_ready != 0) begin
      bad++;
      $display("FAIL %s ready_in_frame: %0d cycles with tx_ready != %b", name, e_ready, READY_IN_FRAME);
    end
    @(negedge clk);
    tx_valid[d] = 1'b0;
    total++;
    if ({tx_done[d], tx_busy[d], tx_out[d], tx_ready[d]} !== 4'b1011) begin
      bad++;
      $display("FAIL %s done_cycle: got done/busy/out/ready=%b required 1011", name,
               {tx_done[d], tx_busy[d], tx_out[d], tx_ready[d]});
    end
    @(negedge clk);
    total++;
    if (tx_done[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse: tx_done=%b one cycle later, required 0", name, tx_done[d]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({tx_out[d], tx_ready[d], tx_busy[d], tx_done[d]} !== 4'b1100) begin
        bad++;
        $display("FAIL reset_in[%0d]: got out/ready/busy/done=%b required 1100", d,
                 {tx_out[d], tx_ready[d], tx_busy[d], tx_done[d]});
      end
    end
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({tx_out[d], tx_ready[d], tx_busy[d], tx_done[d]} !== 4'b1100) begin
        bad++;
        $display("FAIL reset_out[%0d]: got out/ready/busy/done=%b required 1100", d,
                 {tx_out[d], tx_ready[d], tx_busy[d], tx_done[d]});
      end
    end
  endtask

  task automatic test_8n1();
    check_frame(0, 8'h55, 1'b0, "8n1_55");
    for (int i = 0; i < 4; i++) check_frame(0, 8'($urandom_range(0, 255)), 1'b0, "8n1_rand");
  endtask

  task automatic test_parity();
    check_frame(1, 8'h07, 1'b0, "even_07");
    check_frame(2, 8'h07, 1'b0, "odd_07");
    check_frame(2, 8'h00, 1'b0, "odd_00");
    for (int i = 0; i < 3; i++) begin
      check_frame(1, 8'($urandom_range(0, 255)), 1'b0, "even_rand");
      check_frame(2, 8'($urandom_range(0, 255)), 1'b0, "odd_rand");
    end
  endtask

  task automatic test_5bit_2stop();
    check_frame(3, 8'h1F, 1'b0, "5d2s_1f");
    for (int i = 0; i < 3; i++) check_frame(3, 8'($urandom_range(0, 31)), 1'b0, "5d2s_rand");
  endtask

  task automatic test_back_to_back();
    logic [127:0] l1, l2, exp_line, obs_line;
    int           f, len, hs2, exp_hs2;
    bit           ok, drop;
    int           done_q[$];
    int           exp_done_q[$];
    f = build_line(0, 8'hA5, l1);
    void'(build_line(0, 8'h3C, l2));
    len = 2 * f + GAP;
    exp_line = '1;
    for (int i = 0; i < f; i++) begin
      exp_line[i]           = l1[i];
      exp_line[f + GAP + i] = l2[i];
    end
    exp_done_q.push_back(f + 1);
    exp_done_q.push_back(len + 1);
    exp_hs2 = (GAP == 0) ? 1 : f + 1;
    obs_line = '1;
    hs2 = 0;
    drop = 1'b0;
    handshake(0, 8'hA5, 1'b1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b handshake: tx_ready not seen in 200 cycles");
      tx_valid[0] = 1'b0;
      return;
    end
    tx_data[0] = 8'h3C;
    for (int n = 1; n <= len + 3; n++) begin
      @(negedge clk);
      if (drop) tx_valid[0] = 1'b0;
      if (n <= len) obs_line[n-1] = tx_out[0];
      if (tx_done[0] === 1'b1) done_q.push_back(n);
      if (hs2 == 0 && tx_valid[0] && tx_ready[0] === 1'b1) begin
        hs2  = n;
        drop = 1'b1;
      end
    end
    tx_valid[0] = 1'b0;
    total++;
    if (obs_line !== exp_line) begin
      bad++;
      $display("FAIL b2b line: got %h required %h", obs_line, exp_line);
    end
    total++;
    if (hs2 != exp_hs2) begin
      bad++;
      $display("FAIL b2b second_handshake_cycle: got %0d required %0d", hs2, exp_hs2);
    end
    total++;
    if (done_q.size() != 2) begin
      bad++;
      $display("FAIL b2b done_count: got %0d required 2", done_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (done_q[i] != exp_done_q[i]) begin
          bad++;
          $display("FAIL b2b done_cycle[%0d]: got %0d required %0d", i, done_q[i], exp_done_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] exp_line;
    bit           ok;
    int           done_seen;
    void'(build_line(0, 8'h55, exp_line));
    handshake(0, 8'h55, 1'b0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mid_reset handshake: tx_ready not seen in 200 cycles");
      return;
    end
    // Cycles 17..20 carry data bit 3.
    repeat (18) @(negedge clk);
    total++;
    if (tx_out[0] !== exp_line[17]) begin
      bad++;
      $display("FAIL mid_reset bit3: got %b required %b", tx_out[0], exp_line[17]);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({tx_out[0], tx_busy[0], tx_done[0]} !== 3'b100) begin
      bad++;
      $display("FAIL mid_reset immediate: got out/busy/done=%b required 100",
               {tx_out[0], tx_busy[0], tx_done[0]});
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done[0] !== 1'b0) done_seen++;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (tx_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset ready_after: got %b required 1", tx_ready[0]);
    end
    repeat (2) begin
      @(negedge clk);
      if (tx_done[0] !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL mid_reset no_done: got %0d done cycles required 0", done_seen);
    end
    check_frame(0, 8'h81, 1'b0, "after_reset_81");
  endtask

  task automatic test_busy_ignore();
    check_frame(0, 8'($urandom_range(0, 255)), 1'b1, "busy_ignore_a");
    check_frame(0, 8'($urandom_range(0, 255)), 1'b1, "busy_ignore_b");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      tx_data[d]  = '0;
      tx_valid[d] = 1'b0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_5bit_2stop();
    test_back_to_back();
    test_reset_mid_frame();
`ifndef UART_TX_HOLD_EN
    test_busy_ignore();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
